// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: multi-channel maskable interrupt controller.
// Edge-detects N_CHANNELS request lines into IFG flags, masks them with IE,
// picks the highest pending channel index and runs the INT/INTACK handshake
// with the CPU, auto-clearing the serviced flag on acknowledge.
// Optional build macro: IRQ_EDGE_SELECT_EN adds the IES register at
// BASE_ADDR+4, which selects a rising (0) or falling (1) edge per channel.
//
// Handshake: INT is raised in REQ with IntAddrLSBs held stable; the CPU
// answers with INTACK=1, which clears IFG[sel] and moves to ACK
// (irq_active=1); INTACK returning to 0 releases the controller to IDLE.
module irq_priority_ctrl #(
  parameter int          N_CHANNELS  = 8,
  parameter logic [15:0] BASE_ADDR   = 16'h0100,
  parameter logic [5:0]  VECTOR_BASE = 6'd32
) (
  input  logic                  MCLK,
  input  logic                  reset,
  input  logic [N_CHANNELS-1:0] irq_in,
  input  logic [15:0]           MAB,
  input  logic [15:0]           MDBwr,
  input  logic                  MW,
  input  logic                  BW,
  output logic [15:0]           MDBrd,
  output logic                  INT,
  output logic [5:0]            IntAddrLSBs,
  input  logic                  INTACK,
  output logic                  irq_active
);

  localparam logic [15:0] IE_ADDR  = BASE_ADDR;
  localparam logic [15:0] IFG_ADDR = BASE_ADDR + 16'd2;
`ifdef IRQ_EDGE_SELECT_EN
  localparam logic [15:0] IES_ADDR = BASE_ADDR + 16'd4;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [N_CHANNELS-1:0]   ie_q, ie_d;
  logic [N_CHANNELS-1:0]   ifg_q, ifg_d;
  logic [N_CHANNELS-1:0]   prev_q, prev_d;
  logic [3:0]              sel_q, sel_d;
`ifdef IRQ_EDGE_SELECT_EN
  logic [N_CHANNELS-1:0]   ies_q, ies_d;
  logic                    hit_ies;
`endif

  logic                    hit_ie, hit_ifg;
  logic                    wr_lo, wr_hi;
  logic [N_CHANNELS-1:0]   hw_set;
  logic [N_CHANNELS-1:0]   ack_clr;
  logic [N_CHANNELS-1:0]   pend;
  logic [3:0]              win_idx;
  logic [15:0]             ifg_next_w, ie_next_w;
  logic [15:0]             sel_onehot;

  // Merge a byte/word write into an N-bit register; bits >= N_CHANNELS drop.
  function automatic logic [N_CHANNELS-1:0] merge_write(
    input logic [N_CHANNELS-1:0] cur,
    input logic                  lo,
    input logic                  hi,
    input logic [15:0]           data
  );
    logic [15:0] word;
    word = 16'(cur);
    if (lo) word[7:0]  = data[7:0];
    if (hi) word[15:8] = data[15:8];
    return word[N_CHANNELS-1:0];
  endfunction

  // Word-granular address decode; MAB[0] only picks the byte lane.
  assign hit_ie  = (MAB[15:1] == IE_ADDR[15:1]);
  assign hit_ifg = (MAB[15:1] == IFG_ADDR[15:1]);
`ifdef IRQ_EDGE_SELECT_EN
  assign hit_ies = (MAB[15:1] == IES_ADDR[15:1]);
`endif

  // Low lane: word or byte write at an even address. High lane: word write
  // at an even address or byte write at an odd one. Odd word writes are ignored.
  assign wr_lo = MW & ~MAB[0];
  assign wr_hi = MW & (BW ? MAB[0] : ~MAB[0]);

  // Hardware flag-set pulses from the selected edge of each request line.
`ifdef IRQ_EDGE_SELECT_EN
  assign hw_set = (irq_in & ~prev_q & ~ies_q) | (~irq_in & prev_q & ies_q);
`else
  assign hw_set = irq_in & ~prev_q;
`endif

  // Auto-clear mask for the flag being acknowledged this cycle.
  assign sel_onehot = 16'h0001 << sel_q;
  assign ack_clr    = (state_q == ST_REQ && INTACK) ? sel_onehot[N_CHANNELS-1:0]
                                                    : '0;

  // Highest pending channel index wins.
  always_comb begin
    pend    = ifg_q & ie_q;
    win_idx = '0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      if (pend[k]) win_idx = 4'(k);
    end
  end

  // Register next values: software write, then auto-clear, then hardware set
  // so a simultaneous edge always survives a clear.
  always_comb begin
    ie_d   = ie_q;
    ifg_d  = ifg_q;
    prev_d = irq_in;
    if (hit_ie)  ie_d  = merge_write(ie_q, wr_lo, wr_hi, MDBwr);
    if (hit_ifg) ifg_d = merge_write(ifg_q, wr_lo, wr_hi, MDBwr);
    ifg_d = (ifg_d & ~ack_clr) | hw_set;
  end

`ifdef IRQ_EDGE_SELECT_EN
  // Edge-polarity register next value.
  always_comb begin
    ies_d = ies_q;
    if (hit_ies) ies_d = merge_write(ies_q, wr_lo, wr_hi, MDBwr);
  end
`endif

  assign ifg_next_w = 16'(ifg_d);
  assign ie_next_w  = 16'(ie_d);

  // Handshake FSM next state; the selection is latched only on leaving IDLE.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (|pend) begin
          sel_d   = win_idx;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (INTACK) begin
          state_d = ST_ACK;
        end else if (!ifg_next_w[sel_q] || !ie_next_w[sel_q]) begin
          // Software withdrew the request; abandon it without a vector.
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (!INTACK) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and register flops.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ie_q    <= '0;
      ifg_q   <= '0;
      prev_q  <= '0;
      sel_q   <= '0;
`ifdef IRQ_EDGE_SELECT_EN
      ies_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
      ifg_q   <= ifg_d;
      prev_q  <= prev_d;
      sel_q   <= sel_d;
`ifdef IRQ_EDGE_SELECT_EN
      ies_q   <= ies_d;
`endif
    end
  end

  // CPU-facing outputs decoded from the handshake state.
  assign INT         = (state_q == ST_REQ);
  assign irq_active  = (state_q == ST_ACK);
  assign IntAddrLSBs = VECTOR_BASE + {2'b00, sel_q};

  // Side-effect-free register read mux.
  always_comb begin
    MDBrd = '0;
    if (hit_ie)  MDBrd = 16'(ie_q);
    if (hit_ifg) MDBrd = 16'(ifg_q);
`ifdef IRQ_EDGE_SELECT_EN
    if (hit_ies) MDBrd = 16'(ies_q);
`endif
  end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Bench for irq_priority_ctrl (default parameters: 8 channels, base 0x0100,
// vector base 32). Directed table, hand sequences, then random traffic
// checked against a cycle model built from the controller's rules.
module tb_irq_priority_ctrl;

  localparam int N = 8;
  localparam logic [15:0] CH_MASK = 16'h00FF;

  logic        MCLK;
  logic        reset;
  logic [7:0]  irq_in;
  logic [15:0] MAB, MDBwr;
  logic        MW, BW, INTACK;
  logic [15:0] MDBrd;
  logic        INT;
  logic [5:0]  IntAddrLSBs;
  logic        irq_active;

  irq_priority_ctrl #(
    .N_CHANNELS (8),
    .BASE_ADDR  (16'h0100),
    .VECTOR_BASE(6'd32)
  ) dut (
    .MCLK       (MCLK),
    .reset      (reset),
    .irq_in     (irq_in),
    .MAB        (MAB),
    .MDBwr      (MDBwr),
    .MW         (MW),
    .BW         (BW),
    .MDBrd      (MDBrd),
    .INT        (INT),
    .IntAddrLSBs(IntAddrLSBs),
    .INTACK     (INTACK),
    .irq_active (irq_active)
  );

  // Clock and watchdog
  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 = waiting for a pending flag, 1 = requesting, 2 = acknowledged
  logic [15:0] m_ie, m_ifg, m_ies, m_prev;
  int          m_mode;
  int          m_sel;

  function automatic void model_reset();
    m_ie = 0; m_ifg = 0; m_ies = 0; m_prev = 0; m_mode = 0; m_sel = 0;
  endfunction

  function automatic logic [15:0] apply_write(input logic [15:0] cur, input logic lo,
                                              input logic hi, input logic [15:0] data);
    logic [15:0] r;
    r = cur;
    if (lo) r[7:0]  = data[7:0];
    if (hi) r[15:8] = data[15:8];
    return r & CH_MASK;
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] mab);
    logic [15:0] w;
    w = {mab[15:1], 1'b0};
    if (w == 16'h0100) return m_ie;
    if (w == 16'h0102) return m_ifg;
`ifdef IRQ_EDGE_SELECT_EN
    if (w == 16'h0104) return m_ies;
`endif
    return 16'h0000;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void model_step();
    logic [15:0] edges, nie, nifg, nies, pend, w;
    logic lo, hi;
    edges = 0;
    for (int k = 0; k < N; k++) begin
      if (m_ies[k]) edges[k] = m_prev[k] && !irq_in[k];
      else          edges[k] = irq_in[k] && !m_prev[k];
    end
    lo = 0; hi = 0;
    if (MW) begin
      if (!BW && !MAB[0]) begin lo = 1; hi = 1; end
      else if (BW) begin lo = !MAB[0]; hi = MAB[0]; end
    end
    w = {MAB[15:1], 1'b0};
    nie = m_ie; nifg = m_ifg; nies = m_ies;
    if (w == 16'h0100) nie  = apply_write(m_ie, lo, hi, MDBwr);
    if (w == 16'h0102) nifg = apply_write(m_ifg, lo, hi, MDBwr);
`ifdef IRQ_EDGE_SELECT_EN
    if (w == 16'h0104) nies = apply_write(m_ies, lo, hi, MDBwr);
`endif
    if (m_mode == 1 && INTACK) nifg[m_sel] = 1'b0;
    nifg = (nifg | edges) & CH_MASK;
    case (m_mode)
      0: begin
        pend = m_ifg & m_ie;
        if (pend != 0) begin
          for (int k = N - 1; k >= 0; k--) begin
            if (pend[k]) begin m_sel = k; break; end
          end
          m_mode = 1;
        end
      end
      1: begin
        if (INTACK) m_mode = 2;
        else if (!nifg[m_sel] || !nie[m_sel]) m_mode = 0;
      end
      default: if (!INTACK) m_mode = 0;
    endcase
    m_ie = nie; m_ifg = nifg; m_ies = nies;
    m_prev = {8'h00, irq_in};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge MCLK);
    #1;
  endtask

  task automatic apply_reset(input logic [7:0] irq_v);
    reset = 1'b1; irq_in = irq_v; MW = 0; BW = 0; INTACK = 0;
    MAB = 16'h0100; MDBwr = 16'h0000;
    repeat (3) @(posedge MCLK);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0]  irq;
    logic [15:0] mab;
    logic [15:0] wd;
    logic        mw;
    logic        bw;
    logic        ack;
    logic        e_int;
    logic [5:0]  e_vec;
    logic        e_act;
    logic [15:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic void row(input logic [7:0] irq, input logic [15:0] mab,
                              input logic [15:0] wd, input logic mw, input logic bw,
                              input logic ack, input logic e_int, input int e_vec,
                              input logic e_act, input logic [15:0] e_rd);
    vec_t v;
    v.irq = irq; v.mab = mab; v.wd = wd; v.mw = mw; v.bw = bw; v.ack = ack;
    v.e_int = e_int; v.e_vec = 6'(e_vec); v.e_act = e_act; v.e_rd = e_rd;
    tbl.push_back(v);
  endfunction

  // Random-phase scoreboard: {INT, irq_active, vector, read data}
  logic [23:0] exp_q[$];

  initial begin
    logic [23:0] e;
    logic [23:0] a;
    int b;

    //   irq    mab       wd        mw bw ack  INT vec act rd
    // single channel 2 service
    row(8'h00, 16'h0100, 16'h0004, 1, 0, 0,   0, 32, 0, 16'h0004);
    row(8'h04, 16'h0102, 16'h0000, 0, 0, 0,   0, 32, 0, 16'h0004);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 0,   1, 34, 0, 16'h0004);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 0,   1, 34, 0, 16'h0004);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 1,   0, 34, 1, 16'h0000);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 1,   0, 34, 1, 16'h0000);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 0,   0, 34, 0, 16'h0000);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 0,   0, 34, 0, 16'h0000);
    // channels 1 and 6 together: 6 first, then 1
    row(8'h00, 16'h0100, 16'h00FF, 1, 0, 0,   0, 34, 0, 16'h00FF);
    row(8'h42, 16'h0102, 16'h0000, 0, 0, 0,   0, 34, 0, 16'h0042);
    row(8'h42, 16'h0102, 16'h0000, 0, 0, 0,   1, 38, 0, 16'h0042);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 1,   0, 38, 1, 16'h0002);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 0,   0, 38, 0, 16'h0002);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 0,   1, 33, 0, 16'h0002);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 1,   0, 33, 1, 16'h0000);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 0,   0, 33, 0, 16'h0000);
    // channel 3 withdrawn by software while requesting
    row(8'h08, 16'h0102, 16'h0000, 0, 0, 0,   0, 33, 0, 16'h0008);
    row(8'h08, 16'h0102, 16'h0000, 0, 0, 0,   1, 35, 0, 16'h0008);
    row(8'h08, 16'h0102, 16'h0000, 1, 0, 0,   0, 35, 0, 16'h0000);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 0,   0, 35, 0, 16'h0000);
    // channel 5 edge coincides with its own INTACK
    row(8'h20, 16'h0102, 16'h0000, 0, 0, 0,   0, 35, 0, 16'h0020);
    row(8'h20, 16'h0102, 16'h0000, 0, 0, 0,   1, 37, 0, 16'h0020);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 0,   1, 37, 0, 16'h0020);
    row(8'h20, 16'h0102, 16'h0000, 0, 0, 1,   0, 37, 1, 16'h0020);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 0,   0, 37, 0, 16'h0020);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 0,   1, 37, 0, 16'h0020);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 1,   0, 37, 1, 16'h0000);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 0,   0, 37, 0, 16'h0000);
    // byte / word write lanes and unmapped reads
    row(8'h00, 16'h0100, 16'h0000, 1, 0, 0,   0, 37, 0, 16'h0000);
    row(8'h00, 16'h0101, 16'hFFFF, 1, 1, 0,   0, 37, 0, 16'h0000);
    row(8'h00, 16'h0100, 16'hFFFF, 1, 0, 0,   0, 37, 0, 16'h00FF);
    row(8'h00, 16'h0100, 16'h0012, 1, 1, 0,   0, 37, 0, 16'h0012);
    row(8'h00, 16'h0101, 16'h0000, 1, 0, 0,   0, 37, 0, 16'h0012);
    row(8'h00, 16'h0104, 16'h0000, 0, 0, 0,   0, 37, 0, 16'h0000);
    row(8'h00, 16'h0200, 16'h0000, 0, 0, 0,   0, 37, 0, 16'h0000);
    // software-triggered interrupt on channel 4
    row(8'h00, 16'h0102, 16'h0010, 1, 0, 0,   0, 37, 0, 16'h0010);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 0,   1, 36, 0, 16'h0010);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 1,   0, 36, 1, 16'h0000);
    row(8'h00, 16'h0102, 16'h0000, 0, 0, 0,   0, 36, 0, 16'h0000);

    // reset state
    apply_reset(8'h00);
    check("reset INT", {15'd0, INT}, 16'd0);
    check("reset vector", {10'd0, IntAddrLSBs}, 16'd32);
    check("reset irq_active", {15'd0, irq_active}, 16'd0);
    check("reset IE", MDBrd, 16'h0000);
    MAB = 16'h0102;
    #1;
    check("reset IFG", MDBrd, 16'h0000);

    foreach (tbl[i]) begin
      irq_in = tbl[i].irq; MAB = tbl[i].mab; MDBwr = tbl[i].wd;
      MW = tbl[i].mw; BW = tbl[i].bw; INTACK = tbl[i].ack;
      tick();
      check($sformatf("row%0d INT", i), {15'd0, INT}, {15'd0, tbl[i].e_int});
      check($sformatf("row%0d vector", i), {10'd0, IntAddrLSBs}, {10'd0, tbl[i].e_vec});
      check($sformatf("row%0d irq_active", i), {15'd0, irq_active}, {15'd0, tbl[i].e_act});
      check($sformatf("row%0d MDBrd", i), MDBrd, tbl[i].e_rd);
    end

    // line held high through reset sets its flag on the first edge after release
    apply_reset(8'h01);
    MAB = 16'h0102;
    #1;
    check("held-high before edge IFG", MDBrd, 16'h0000);
    tick();
    check("held-high after edge IFG", MDBrd, 16'h0001);
    check("held-high masked INT", {15'd0, INT}, 16'd0);

`ifdef IRQ_EDGE_SELECT_EN
    // falling-edge selection on channel 0
    apply_reset(8'h00);
    MAB = 16'h0104; MDBwr = 16'h0001; MW = 1;
    tick();
    check("IES readback", MDBrd, 16'h0001);
    MW = 0; MAB = 16'h0102;
    tick();
    check("IES write no flag", MDBrd, 16'h0000);
    irq_in = 8'h01;
    tick();
    check("IES rising ignored", MDBrd, 16'h0000);
    irq_in = 8'h00;
    tick();
    check("IES falling sets", MDBrd, 16'h0001);
`else
    // IES slot is unmapped in this build
    apply_reset(8'h00);
    MAB = 16'h0104; MDBwr = 16'hFFFF; MW = 1;
    tick();
    check("unmapped +4 after write", MDBrd, 16'h0000);
    MW = 0; irq_in = 8'h01; MAB = 16'h0102;
    tick();
    check("rising edge sets flag", MDBrd, 16'h0001);
    irq_in = 8'h00;
    tick();
    check("falling edge no extra", MDBrd, 16'h0001);
`endif

    // randomized traffic against the model
    apply_reset(8'h00);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = $urandom_range(0, 7);
        irq_in[b] = ~irq_in[b];
      end
      MW    = ($urandom_range(0, 5) == 0);
      BW    = 1'($urandom_range(0, 1));
      MAB   = ($urandom_range(0, 15) == 0) ? 16'h0200 : 16'h0100 + 16'($urandom_range(0, 5));
      MDBwr = 16'($urandom);
      case (m_mode)
        1:       INTACK = ($urandom_range(0, 2) == 0);
        2:       INTACK = ($urandom_range(0, 1) == 0);
        default: INTACK = ($urandom_range(0, 9) == 0);
      endcase
      tick();
      exp_q.push_back({(m_mode == 1), (m_mode == 2), 6'(32 + m_sel), model_read(MAB)});
      e = exp_q.pop_front();
      a = {INT, irq_active, IntAddrLSBs, MDBrd};
      check($sformatf("rand%0d INT", c), {15'd0, a[23]}, {15'd0, e[23]});
      check($sformatf("rand%0d irq_active", c), {15'd0, a[22]}, {15'd0, e[22]});
      check($sformatf("rand%0d vector", c), {10'd0, a[21:16]}, {10'd0, e[21:16]});
      check($sformatf("rand%0d MDBrd", c), a[15:0], e[15:0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
